// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: reset PC default, NOP encoding and the IF/ID bundle
// consumed by the decode stage.
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   // Instruction addresses are word aligned; the low two bits never reach PC.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load when enabled, flush to a bubble, synchronous
// reset to the bubble value.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_en,
   input  logic        i_flush,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   if_id_t r_slot;
   if_id_t w_bubble;

   assign w_bubble = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

   // The slot is either VALID (a fetched word) or BUBBLE; only reset and
   // flush create a BUBBLE, a disabled cycle keeps whatever is there.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot <= w_bubble;
      end else if (i_en) begin
         if (i_flush) begin
            r_slot <= w_bubble;
         end else begin
            r_slot <= '{instr: i_instr, pc: i_pc, pc4: i_pc4, valid: 1'b1};
         end
      end
   end

   assign o_instr = r_slot.instr;
   assign o_pc    = r_slot.pc;
   assign o_pc4   = r_slot.pc4;
   assign o_valid = r_slot.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux and the IF/ID register.
// Define FETCH_DELAY_SLOT_EN for branch-delay-slot semantics; otherwise a redirect flushes IF/ID.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP      = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic [31:0] PC,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PC4D,
   output logic        ValidD
);

   // Flow control: Stall high freezes PC and IF/ID and masks Redirect; decode
   // holds Redirect/RedirectPC until a cycle with Stall low consumes them.
   // ValidD high means InstrD/PCD/PC4D describe a real fetched instruction.
   logic [31:0] r_pc;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_next;
   logic        w_advance;
   logic        w_flush;

   assign w_advance  = ~Stall;
   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_pc_next = w_pc_plus4;
      if (Redirect) begin
         w_pc_next = word_align(RedirectPC);
      end
   end

`ifdef FETCH_DELAY_SLOT_EN
   // The word after the branch is the delay slot and must still execute.
   assign w_flush = 1'b0;
`else
   assign w_flush = Redirect;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (w_advance) begin
         r_pc <= w_pc_next;
      end
   end

   assign PC = r_pc;

   if_id_reg #(
      .NOP (NOP)
   ) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_advance),
      .i_flush (w_flush),
      .i_instr (Instr),
      .i_pc    (r_pc),
      .i_pc4   (w_pc_plus4),
      .o_instr (InstrD),
      .o_pc    (PCD),
      .o_pc4   (PC4D),
      .o_valid (ValidD)
   );

endmodule
